// File: rtl/ccip_if_pkg.sv
// Minimal CCI-P MMIO channel types (c0 Rx request, c2 Tx response) used by the CSR bank.
package ccip_if_pkg;
    typedef logic [15:0] t_ccip_mmioAddr;
    typedef logic [8:0]  t_ccip_tid;
    typedef logic [63:0] t_ccip_mmioData;

    localparam logic [1:0] CCIP_LEN_4B = 2'b00;
    localparam logic [1:0] CCIP_LEN_8B = 2'b01;

    typedef struct packed {
        t_ccip_mmioAddr address;
        logic [1:0]     length;
        logic           rsvd;
        t_ccip_tid      tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        t_ccip_mmioData      data;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_tid tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        t_ccip_mmioData      data;
    } t_if_ccip_c2_Tx;
endpackage

// File: rtl/hc_csr_pkg.sv
// HardCloud CSR bank shared definitions: address map, control codes, descriptor type, decode helpers.
package hc_csr_pkg;
    import ccip_if_pkg::*;

    // Dword address of 0x100; qword index q = (dword - base) >> 1.
    localparam logic [15:0] HC_BASE_DW   = 16'h0040;
    localparam logic [5:0]  HC_Q_STATUS  = 6'd0;
    localparam logic [5:0]  HC_Q_CYCLES  = 6'd1;
    localparam logic [5:0]  HC_Q_DSM     = 6'd2;
    localparam logic [5:0]  HC_Q_CONTROL = 6'd3;
    localparam logic [5:0]  HC_Q_BUF0    = 6'd4;

    localparam logic [31:0] HC_CMD_ASSERT_RST   = 32'h0;
    localparam logic [31:0] HC_CMD_DEASSERT_RST = 32'h1;
    localparam logic [31:0] HC_CMD_START        = 32'h3;
    localparam logic [31:0] HC_CMD_STOP         = 32'h7;

    typedef struct packed {
        logic [63:0] address;
        logic [31:0] size;
    } t_hc_buffer;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_IDLE  = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } t_hc_ctrl_state;

    function automatic logic hc_in_window(input t_ccip_mmioAddr addr, input int unsigned n_buffers);
        logic [15:0] top_dw;
        top_dw = 16'(32'h48 + 32'(4 * n_buffers) - 32'd1);
        return (addr >= HC_BASE_DW) && (addr <= top_dw);
    endfunction

    function automatic logic [5:0] hc_qword_idx(input t_ccip_mmioAddr addr);
        return 6'((addr - HC_BASE_DW) >> 1);
    endfunction

    // 4B writes carry their payload in data[31:0] and land in the dword picked by address[0].
    function automatic logic [63:0] hc_merge(input logic [63:0] old_val, input t_ccip_mmioData wr_data,
                                             input logic is_8b, input logic upper);
        if (is_8b)
            return wr_data;
        if (upper)
            return {wr_data[31:0], old_val[31:0]};
        return {old_val[63:32], wr_data[31:0]};
    endfunction
endpackage

// File: rtl/hc_ctrl_fsm.sv
// Accelerator control state machine: run/reset handshake, done tracking and run-cycle counter.
module hc_ctrl_fsm
    import hc_csr_pkg::*;
#(
    parameter int CNT_W = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_wr,
    input  logic [31:0]      ctrl_code,
    input  logic             hc_done,
    output t_hc_ctrl_state   state,
    output logic             done_seen,
    output logic [CNT_W-1:0] cycles,
    output logic             hc_afu_rst,
    output logic             hc_start,
    output logic             hc_running
);
    t_hc_ctrl_state   state_reg;
    logic             done_seen_reg;
    logic [CNT_W-1:0] cycles_reg;
    logic             afu_rst_reg;
    logic             start_reg;
    logic             running_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_RESET;
            done_seen_reg <= 1'b0;
            cycles_reg    <= '0;
            afu_rst_reg   <= 1'b1;
            start_reg     <= 1'b0;
            running_reg   <= 1'b0;
        end else begin
            start_reg <= 1'b0;
            if (state_reg == S_RUN && cycles_reg != '1)
                cycles_reg <= cycles_reg + CNT_W'(1);
            // A legal command always beats a concurrent hc_done.
            if (ctrl_wr && ctrl_code == HC_CMD_ASSERT_RST) begin
                state_reg   <= S_RESET;
                afu_rst_reg <= 1'b1;
                running_reg <= 1'b0;
            end else if (ctrl_wr && ctrl_code == HC_CMD_DEASSERT_RST && state_reg == S_RESET) begin
                state_reg   <= S_IDLE;
                afu_rst_reg <= 1'b0;
            end else if (ctrl_wr && ctrl_code == HC_CMD_START &&
                         (state_reg == S_IDLE || state_reg == S_DONE)) begin
                state_reg     <= S_RUN;
                start_reg     <= 1'b1;
                running_reg   <= 1'b1;
                cycles_reg    <= '0;
                done_seen_reg <= 1'b0;
            end else if (ctrl_wr && ctrl_code == HC_CMD_STOP &&
                         (state_reg == S_RUN || state_reg == S_DONE)) begin
                state_reg   <= S_IDLE;
                running_reg <= 1'b0;
            end else if (state_reg == S_RUN && hc_done) begin
                state_reg     <= S_DONE;
                running_reg   <= 1'b0;
                done_seen_reg <= 1'b1;
            end
        end
    end

    assign state      = state_reg;
    assign done_seen  = done_seen_reg;
    assign cycles     = cycles_reg;
    assign hc_afu_rst = afu_rst_reg;
    assign hc_start   = start_reg;
    assign hc_running = running_reg;
endmodule

// File: rtl/hc_csr_bank.sv
// HardCloud AFU CSR bank: decodes MMIO in 0x100..TOP, holds DSM/descriptors, returns reads in 2 clk.
module hc_csr_bank
    import ccip_if_pkg::*;
    import hc_csr_pkg::*;
#(
    parameter int N_BUFFERS = 4,
    parameter int CNT_W     = 48
) (
    input  logic                       clk,
    input  logic                       reset,
    input  t_if_ccip_c0_Rx             rx_c0,
    output t_if_ccip_c2_Tx             tx_c2,
    output logic [63:0]                hc_dsm_base,
    output t_hc_buffer [N_BUFFERS-1:0] hc_buffer,
    output logic                       hc_afu_rst,
    output logic                       hc_start,
    output logic                       hc_running,
    input  logic                       hc_done
);
    t_ccip_c0_ReqMmioHdr mmio_hdr;
    logic                in_win;
    logic [5:0]          req_q;
    logic                wr_en;
    logic                is_8b;
    logic                ctrl_wr;
    t_hc_ctrl_state      state;
    logic                done_seen;
    logic [CNT_W-1:0]    cycles;
    logic [63:0]         dsm_reg;
    logic                unused_rsvd;

    assign mmio_hdr    = rx_c0.hdr;
    assign in_win      = hc_in_window(mmio_hdr.address, N_BUFFERS);
    assign req_q       = hc_qword_idx(mmio_hdr.address);
    assign wr_en       = rx_c0.mmioWrValid && in_win;
    assign is_8b       = (mmio_hdr.length == CCIP_LEN_8B);
    assign ctrl_wr     = wr_en && req_q == HC_Q_CONTROL && !mmio_hdr.address[0];
    assign unused_rsvd = mmio_hdr.rsvd;

    hc_ctrl_fsm #(.CNT_W(CNT_W)) u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .ctrl_wr    (ctrl_wr),
        .ctrl_code  (rx_c0.data[31:0]),
        .hc_done    (hc_done),
        .state      (state),
        .done_seen  (done_seen),
        .cycles     (cycles),
        .hc_afu_rst (hc_afu_rst),
        .hc_start   (hc_start),
        .hc_running (hc_running)
    );

    always_ff @(posedge clk) begin
        if (reset)
            dsm_reg <= '0;
        else if (wr_en && req_q == HC_Q_DSM)
            dsm_reg <= hc_merge(dsm_reg, rx_c0.data, is_8b, mmio_hdr.address[0]);
    end
    assign hc_dsm_base = dsm_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_BUFFERS; gi++) begin : g_buf
            logic [63:0] addr_reg;
            logic [31:0] size_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    addr_reg <= '0;
                    size_reg <= '0;
                end else if (wr_en && req_q == 6'(HC_Q_BUF0 + 6'(2 * gi))) begin
                    addr_reg <= hc_merge(addr_reg, rx_c0.data, is_8b, mmio_hdr.address[0]);
                end else if (wr_en && req_q == 6'(HC_Q_BUF0 + 6'(2 * gi + 1)) &&
                             (is_8b || !mmio_hdr.address[0])) begin
                    size_reg <= rx_c0.data[31:0];
                end
            end
            assign hc_buffer[gi] = {addr_reg, size_reg};
        end
    endgenerate

    // Stage 1 latches the request; stage 2 samples the register file so it reflects prior writes.
    logic        rd_s1_valid_reg;
    t_ccip_tid   rd_s1_tid_reg;
    logic [5:0]  rd_s1_q_reg;
    logic        tx_valid_reg;
    t_ccip_tid   tx_tid_reg;
    logic [63:0] tx_data_reg;
    logic [63:0] rd_data;

    always_comb begin
        rd_data = '0;
        case (rd_s1_q_reg)
            HC_Q_STATUS:  rd_data = {60'b0, state, done_seen, hc_running};
            HC_Q_CYCLES:  rd_data = 64'(cycles);
            HC_Q_DSM:     rd_data = dsm_reg;
            HC_Q_CONTROL: rd_data = '0;
            default: begin
                for (int i = 0; i < N_BUFFERS; i++) begin
                    if (rd_s1_q_reg == 6'(HC_Q_BUF0 + 6'(2 * i)))
                        rd_data = hc_buffer[i].address;
                    else if (rd_s1_q_reg == 6'(HC_Q_BUF0 + 6'(2 * i + 1)))
                        rd_data = {32'b0, hc_buffer[i].size};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_s1_valid_reg <= 1'b0;
            rd_s1_tid_reg   <= '0;
            rd_s1_q_reg     <= '0;
            tx_valid_reg    <= 1'b0;
            tx_tid_reg      <= '0;
            tx_data_reg     <= '0;
        end else begin
            rd_s1_valid_reg <= rx_c0.mmioRdValid && in_win;
            rd_s1_tid_reg   <= mmio_hdr.tid;
            rd_s1_q_reg     <= req_q;
            tx_valid_reg    <= rd_s1_valid_reg;
            tx_tid_reg      <= rd_s1_tid_reg;
            tx_data_reg     <= rd_data;
        end
    end

    assign tx_c2.mmioRdValid = tx_valid_reg;
    assign tx_c2.hdr.tid     = tx_tid_reg;
    assign tx_c2.data        = tx_data_reg;
endmodule

// File: tb/tb_hc_csr_bank.sv
// Directed bench for hc_csr_bank: register map, write merging, control FSM and read pipeline.
module tb_hc_csr_bank;
    import ccip_if_pkg::*;
    import hc_csr_pkg::*;

    localparam int N_BUFFERS = 4;
    localparam int CNT_W     = 48;

    logic                       clk = 1'b0;
    logic                       reset;
    t_if_ccip_c0_Rx             rx_c0;
    t_if_ccip_c2_Tx             tx_c2;
    logic [63:0]                hc_dsm_base;
    t_hc_buffer [N_BUFFERS-1:0] hc_buffer;
    logic                       hc_afu_rst;
    logic                       hc_start;
    logic                       hc_running;
    logic                       hc_done;

    int total = 0;
    int bad   = 0;

    hc_csr_bank #(.N_BUFFERS(N_BUFFERS), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_c0       (rx_c0),
        .tx_c2       (tx_c2),
        .hc_dsm_base (hc_dsm_base),
        .hc_buffer   (hc_buffer),
        .hc_afu_rst  (hc_afu_rst),
        .hc_start    (hc_start),
        .hc_running  (hc_running),
        .hc_done     (hc_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_req(input logic [15:0] byte_addr, input logic [8:0] tid, input logic is8);
        rx_c0.hdr.address = byte_addr >> 2;
        rx_c0.hdr.tid     = tid;
        rx_c0.hdr.length  = is8 ? CCIP_LEN_8B : CCIP_LEN_4B;
    endtask

    task automatic mmio_write(input logic [15:0] byte_addr, input logic is8, input logic [63:0] data);
        set_req(byte_addr, 9'd0, is8);
        rx_c0.data        = data;
        rx_c0.mmioWrValid = 1'b1;
        tick();
        rx_c0.mmioWrValid = 1'b0;
    endtask

    task automatic ctrl(input logic [31:0] code);
        mmio_write(16'h0118, 1'b1, {32'b0, code});
    endtask

    task automatic mmio_read(input string tag, input logic [15:0] byte_addr, input logic [8:0] tid,
                             input logic is8, input logic [63:0] exp);
        set_req(byte_addr, tid, is8);
        rx_c0.mmioRdValid = 1'b1;
        tick();
        rx_c0.mmioRdValid = 1'b0;
        chk({tag, ".lat1"}, 64'(tx_c2.mmioRdValid), 64'd0);
        tick();
        chk({tag, ".vld"}, 64'(tx_c2.mmioRdValid), 64'd1);
        chk({tag, ".tid"}, 64'(tx_c2.hdr.tid), 64'(tid));
        chk({tag, ".data"}, tx_c2.data, exp);
    endtask

    initial begin
        reset   = 1'b1;
        hc_done = 1'b0;
        rx_c0   = '0;
        repeat (3) tick();
        chk("rst.afu_rst", 64'(hc_afu_rst), 64'd1);
        chk("rst.start", 64'(hc_start), 64'd0);
        chk("rst.running", 64'(hc_running), 64'd0);
        chk("rst.rdvalid", 64'(tx_c2.mmioRdValid), 64'd0);
        chk("rst.dsm", hc_dsm_base, 64'd0);
        chk("rst.buf", 64'(hc_buffer == '0), 64'd1);
        reset = 1'b0;
        tick();

        mmio_read("status0", 16'h0100, 9'd5, 1'b1, 64'h0);

        mmio_write(16'h0120, 1'b1, 64'hDEAD_BEEF_0000_1000);
        mmio_write(16'h0128, 1'b0, 64'h40);
        chk("buf0.addr", hc_buffer[0].address, 64'hDEAD_BEEF_0000_1000);
        chk("buf0.size", 64'(hc_buffer[0].size), 64'h40);
        mmio_read("rd.buf0addr", 16'h0120, 9'd1, 1'b1, 64'hDEAD_BEEF_0000_1000);
        mmio_read("rd.buf0size", 16'h0128, 9'd2, 1'b1, 64'h40);
        mmio_read("rd.buf0addr_hi4", 16'h0124, 9'd3, 1'b0, 64'hDEAD_BEEF_0000_1000);

        mmio_write(16'h0130, 1'b1, 64'hFFFF_FFFF);
        mmio_write(16'h0134, 1'b0, 64'h1);
        chk("buf1.addr", hc_buffer[1].address, 64'h1_FFFF_FFFF);
        mmio_write(16'h012C, 1'b0, 64'h55);
        chk("buf0.size_hi_ignored", 64'(hc_buffer[0].size), 64'h40);
        mmio_write(16'h0100, 1'b1, 64'hFFFF);
        mmio_read("status_wr_ignored", 16'h0100, 9'd4, 1'b1, 64'h0);

        ctrl(HC_CMD_START);
        chk("start_in_reset.start", 64'(hc_start), 64'd0);
        chk("start_in_reset.afu_rst", 64'(hc_afu_rst), 64'd1);
        mmio_read("start_in_reset.status", 16'h0100, 9'd6, 1'b1, 64'h0);

        ctrl(HC_CMD_DEASSERT_RST);
        chk("deassert.afu_rst", 64'(hc_afu_rst), 64'd0);
        mmio_read("idle.status", 16'h0100, 9'd7, 1'b1, 64'h4);

        ctrl(HC_CMD_START);
        chk("run.start_pulse", 64'(hc_start), 64'd1);
        chk("run.running", 64'(hc_running), 64'd1);
        tick();
        chk("run.start_cleared", 64'(hc_start), 64'd0);
        repeat (98) tick();
        hc_done = 1'b1;
        tick();
        hc_done = 1'b0;
        chk("done.running", 64'(hc_running), 64'd0);
        mmio_read("done.cycles", 16'h0108, 9'd8, 1'b1, 64'd100);
        mmio_read("done.status", 16'h0100, 9'd9, 1'b1, 64'hE);
        mmio_read("control_reads0", 16'h0118, 9'd10, 1'b1, 64'h0);

        ctrl(HC_CMD_START);
        mmio_read("rerun.status", 16'h0100, 9'd11, 1'b1, 64'h9);
        hc_done = 1'b1;
        ctrl(HC_CMD_STOP);
        hc_done = 1'b0;
        chk("stop_vs_done.running", 64'(hc_running), 64'd0);
        mmio_read("stop_vs_done.status", 16'h0100, 9'd12, 1'b1, 64'h4);

        mmio_write(16'h0110, 1'b1, 64'h1234_5678_9ABC_DEF0);
        chk("dsm.out", hc_dsm_base, 64'h1234_5678_9ABC_DEF0);
        set_req(16'h0110, 9'd7, 1'b1);
        rx_c0.mmioRdValid = 1'b1;
        tick();
        chk("b2b.lat", 64'(tx_c2.mmioRdValid), 64'd0);
        set_req(16'h0118, 9'd8, 1'b1);
        tick();
        chk("b2b.r1.vld", 64'(tx_c2.mmioRdValid), 64'd1);
        chk("b2b.r1.tid", 64'(tx_c2.hdr.tid), 64'd7);
        chk("b2b.r1.data", tx_c2.data, 64'h1234_5678_9ABC_DEF0);
        set_req(16'h0200, 9'd9, 1'b1);
        tick();
        rx_c0.mmioRdValid = 1'b0;
        chk("b2b.r2.vld", 64'(tx_c2.mmioRdValid), 64'd1);
        chk("b2b.r2.tid", 64'(tx_c2.hdr.tid), 64'd8);
        chk("b2b.r2.data", tx_c2.data, 64'h0);
        tick();
        chk("b2b.oor.none1", 64'(tx_c2.mmioRdValid), 64'd0);
        tick();
        chk("b2b.oor.none2", 64'(tx_c2.mmioRdValid), 64'd0);

        mmio_write(16'h0158, 1'b0, 64'h99);
        chk("buf3.size", 64'(hc_buffer[3].size), 64'h99);
        mmio_read("top_dword", 16'h015C, 9'd13, 1'b0, 64'h99);
        mmio_write(16'h0160, 1'b1, 64'hAAAA);
        chk("oor_write.buf", 64'(hc_buffer[3].size), 64'h99);
        set_req(16'h0160, 9'd14, 1'b1);
        rx_c0.mmioRdValid = 1'b1;
        tick();
        rx_c0.mmioRdValid = 1'b0;
        tick();
        chk("above_top.none", 64'(tx_c2.mmioRdValid), 64'd0);
        tick();
        chk("above_top.none2", 64'(tx_c2.mmioRdValid), 64'd0);

        ctrl(HC_CMD_ASSERT_RST);
        chk("assert_rst.afu_rst", 64'(hc_afu_rst), 64'd1);
        mmio_read("assert_rst.status", 16'h0100, 9'd15, 1'b1, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
